// File: rtl/axi_pkg.sv
// Shared AXI4 types for the master arbiter: channel payload structs and FSM states.
// Slave-side IDs carry the master index prefix, so every id field is sized for it.
package axi_pkg;
  localparam int AXI_ID_LEN = 4;
  localparam int AXI_NM     = 2;
  localparam int AXI_IDX    = $clog2(AXI_NM);
  localparam int AXI_SID_W  = AXI_ID_LEN + AXI_IDX;
  localparam int AXI_DATA_W = 128;
  localparam int AXI_ADDR_W = 32;

  typedef struct packed {
    logic [AXI_SID_W-1:0]  id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  lock;
    logic [3:0]            cache;
  } axi_ax_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0]   data;
    logic [AXI_DATA_W/8-1:0] strb;
    logic                    last;
  } axi_w_t;

  typedef struct packed {
    logic [AXI_SID_W-1:0]  id;
    logic [AXI_DATA_W-1:0] data;
    logic                  last;
  } axi_r_t;

  typedef struct packed {
    logic [AXI_SID_W-1:0] id;
    logic [1:0]           resp;
  } axi_b_t;

  typedef enum logic {AW_ARB, AW_FWD} WrState_t;
  typedef enum logic {AR_ARB, AR_FWD} RdState_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester at or after ptr, wrapping modulo NM (NM power of two).
module rr_arbiter #(
  parameter  int NM  = 2,
  localparam int IDX = $clog2(NM)
) (
  input  logic [NM-1:0]  req,
  input  logic [IDX-1:0] ptr,
  output logic [IDX-1:0] gnt,
  output logic           any
);
  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    gnt = ptr;
    for (int k = NM-1; k >= 0; k--) begin
      if (req[ptr + IDX'(k)]) gnt = ptr + IDX'(k);
    end
  end

  assign any = |req;
endmodule

// File: rtl/axi_master_arbiter.sv
// Shares one AXI4 slave port between NM masters. AW and AR are arbitrated independently
// round-robin; W follows the AW winner until wlast. The master index is prefixed onto the
// slave-side ID, and R/B are steered back by that prefix with no buffering.
// Struct widths come from axi_pkg; the parameters must agree with it.
module axi_master_arbiter
  import axi_pkg::*;
#(
  parameter int NM       = AXI_NM,
  parameter int WIDTH    = AXI_DATA_W,
  parameter int ADDR_LEN = AXI_ADDR_W,
  parameter int ID_W     = AXI_ID_LEN
) (
  input  logic                         clk,
  input  logic                         rst,
  input  axi_ax_t [NM-1:0]             m_aw,
  input  logic    [NM-1:0]             m_awvalid,
  output logic    [NM-1:0]             m_awready,
  input  axi_w_t  [NM-1:0]             m_w,
  input  logic    [NM-1:0]             m_wvalid,
  output logic    [NM-1:0]             m_wready,
  output logic    [ID_W-1:0]           m_bid,
  output logic    [NM-1:0]             m_bvalid,
  input  logic    [NM-1:0]             m_bready,
  input  axi_ax_t [NM-1:0]             m_ar,
  input  logic    [NM-1:0]             m_arvalid,
  output logic    [NM-1:0]             m_arready,
  output axi_r_t                       m_r,
  output logic    [NM-1:0]             m_rvalid,
  input  logic    [NM-1:0]             m_rready,
  output axi_ax_t                      s_aw,
  output logic                         s_awvalid,
  input  logic                         s_awready,
  output axi_w_t                       s_w,
  output logic                         s_wvalid,
  input  logic                         s_wready,
  input  logic    [ID_W+$clog2(NM)-1:0] s_bid,
  input  logic                         s_bvalid,
  output logic                         s_bready,
  output axi_ax_t                      s_ar,
  output logic                         s_arvalid,
  input  logic                         s_arready,
  input  axi_r_t                       s_r,
  input  logic                         s_rvalid,
  output logic                         s_rready
);
  localparam int IDX   = $clog2(NM);
  localparam int SID_W = ID_W + IDX;

  if (WIDTH != AXI_DATA_W || ADDR_LEN != AXI_ADDR_W || SID_W != AXI_SID_W ||
      NM < 2 || (1 << IDX) != NM) begin : g_bad_cfg
    $error("axi_master_arbiter: parameters disagree with axi_pkg or NM not a power of two");
  end

  // ---------------- write address / data ----------------
  WrState_t       wr_st, wr_st_n;
  logic [IDX-1:0] wgnt, wgnt_n, wptr, wptr_n, aw_pick;
  logic           aw_done, aw_done_n, w_done, w_done_n, aw_any;
  logic           aw_hs, w_last_hs;

  rr_arbiter #(.NM(NM)) u_aw_arb (.req(m_awvalid), .ptr(wptr), .gnt(aw_pick), .any(aw_any));

  assign aw_hs     = s_awvalid & s_awready;
  assign w_last_hs = s_wvalid & s_wready & s_w.last;

  // Write FSM state, grant, pointer and per-burst completion flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_st   <= AW_ARB;
      wgnt    <= '0;
      wptr    <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      wr_st   <= wr_st_n;
      wgnt    <= wgnt_n;
      wptr    <= wptr_n;
      aw_done <= aw_done_n;
      w_done  <= w_done_n;
    end
  end

  // Write next-state: hold the grant until both the AW and the wlast handshakes are seen.
  always_comb begin
    wr_st_n   = wr_st;
    wgnt_n    = wgnt;
    wptr_n    = wptr;
    aw_done_n = aw_done;
    w_done_n  = w_done;
    unique case (wr_st)
      AW_ARB: if (aw_any) begin
        wgnt_n  = aw_pick;
        wr_st_n = AW_FWD;
      end
      AW_FWD: begin
        aw_done_n = aw_done | aw_hs;
        w_done_n  = w_done | w_last_hs;
        if (aw_done_n && w_done_n) begin
          wr_st_n   = AW_ARB;
          wptr_n    = wgnt + IDX'(1);
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
        end
      end
      default: wr_st_n = AW_ARB;
    endcase
  end

  // Forward the granted master's AW/W; a finished half is gated so the next burst can't leak.
  always_comb begin
    s_aw      = '0;
    s_awvalid = 1'b0;
    s_w       = '0;
    s_wvalid  = 1'b0;
    m_awready = '0;
    m_wready  = '0;
    if (wr_st == AW_FWD) begin
      s_aw            = m_aw[wgnt];
      s_aw.id         = {wgnt, m_aw[wgnt].id[ID_W-1:0]};
      s_awvalid       = m_awvalid[wgnt] & ~aw_done;
      m_awready[wgnt] = s_awready & ~aw_done;
      s_w             = m_w[wgnt];
      s_wvalid        = m_wvalid[wgnt] & ~w_done;
      m_wready[wgnt]  = s_wready & ~w_done;
    end
  end

  // ---------------- read address ----------------
  RdState_t       rd_st, rd_st_n;
  logic [IDX-1:0] rgnt, rgnt_n, rptr, rptr_n, ar_pick;
  logic           ar_any, ar_hs;

  rr_arbiter #(.NM(NM)) u_ar_arb (.req(m_arvalid), .ptr(rptr), .gnt(ar_pick), .any(ar_any));

  assign ar_hs = s_arvalid & s_arready;

  // Read FSM state, grant and pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_st <= AR_ARB;
      rgnt  <= '0;
      rptr  <= '0;
    end else begin
      rd_st <= rd_st_n;
      rgnt  <= rgnt_n;
      rptr  <= rptr_n;
    end
  end

  // Read next-state: one AR per grant, leave on its handshake.
  always_comb begin
    rd_st_n = rd_st;
    rgnt_n  = rgnt;
    rptr_n  = rptr;
    unique case (rd_st)
      AR_ARB: if (ar_any) begin
        rgnt_n  = ar_pick;
        rd_st_n = AR_FWD;
      end
      AR_FWD: if (ar_hs) begin
        rd_st_n = AR_ARB;
        rptr_n  = rgnt + IDX'(1);
      end
      default: rd_st_n = AR_ARB;
    endcase
  end

  // Forward the granted master's AR with its index prefixed onto the ID.
  always_comb begin
    s_ar      = '0;
    s_arvalid = 1'b0;
    m_arready = '0;
    if (rd_st == AR_FWD) begin
      s_ar            = m_ar[rgnt];
      s_ar.id         = {rgnt, m_ar[rgnt].id[ID_W-1:0]};
      s_arvalid       = m_arvalid[rgnt];
      m_arready[rgnt] = s_arready;
    end
  end

  // ---------------- response routing ----------------
  logic [IDX-1:0] r_sel, b_sel;

  assign r_sel = s_r.id[SID_W-1 -: IDX];
  assign b_sel = s_bid[SID_W-1 -: IDX];
  assign m_bid = s_bid[ID_W-1:0];

  // Steer R/B to the master named by the ID prefix; payload is shared, only valid is per master.
  always_comb begin
    m_r           = s_r;
    m_r.id        = SID_W'(s_r.id[ID_W-1:0]);
    m_rvalid      = '0;
    m_bvalid      = '0;
    m_rvalid[r_sel] = s_rvalid;
    m_bvalid[b_sel] = s_bvalid;
    s_rready      = m_rready[r_sel];
    s_bready      = m_bready[b_sel];
  end
endmodule
